video_timing_gen: RTL and testbench

- Parametrised successor to the fixed-size dummy video source: a full raster timing generator with a test-pattern engine, driving the video interface from the core clock.
- Derives a pixel clock-enable from the core clock by integer division.
- Generates active-high hsync/vsync, data-enable, aligned x/y coordinates and a frame counter, so real core video can later replace the pattern path without any timing change.
- Sits between the core PLL outputs and the video_if signals in athena_top.

---
 rtl/video_timing_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator with a built-in test-pattern engine.
// Produces a pixel enable, syncs, data enable, aligned x/y, RGB and a frame counter.
module video_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FP     = 8,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 640,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FP     = 4,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] pattern_color,
    output logic        pix_ce,
    output logic        de,
    output logic        hs,
    output logic        vs,
    output logic [23:0] rgb,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [DIV_W-1:0]  DivLast = DIV_W'(CLK_DIV - 1);
    localparam logic [BAR_CW-1:0] BarLast = BAR_CW'(BAR_W - 1);
    localparam logic [11:0]       HLast   = 12'(H_TOTAL - 1);
    localparam logic [11:0]       VLast   = 12'(V_TOTAL - 1);
    localparam logic [11:0]       HAct    = 12'(H_ACTIVE);
    localparam logic [11:0]       VAct    = 12'(V_ACTIVE);
    localparam logic [11:0]       HsStart = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0]       HsEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0]       VsStart = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0]       VsEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] PatSolid = 2'd0;
    localparam logic [1:0] PatBars  = 2'd1;
    localparam logic [1:0] PatGrid  = 2'd2;
    localparam logic [1:0] PatGrad  = 2'd3;

    logic [DIV_W-1:0]  div_q, div_d;
    logic              ce_q, ce_d;
    logic [11:0]       hc_q, hc_d;
    logic [11:0]       vc_q, vc_d;
    logic [BAR_CW-1:0] bar_px_q, bar_px_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [1:0]        pat_q, pat_d;
    logic [23:0]       col_q, col_d;
    logic [15:0]       fc_q, fc_d;
    logic              de_q, de_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [23:0]       rgb_q, rgb_d;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;

    logic              active;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              frame_start;
    logic [1:0]        pat_eff;
    logic [23:0]       col_eff;
    logic [23:0]       bar_rgb;
    logic [23:0]       pat_rgb;

    // pix_ce is registered from the next divider value so it is low while in reset.
    always_comb begin
        div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
        ce_d  = (div_d == DivLast);
    end

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce_q) begin
            if (hc_q == HLast) begin
                hc_d = 12'd0;
                vc_d = (vc_q == VLast) ? 12'd0 : vc_q + 12'd1;
            end else begin
                hc_d = hc_q + 12'd1;
            end
        end
    end

    // Bar position tracked incrementally so no divider by H_ACTIVE/8 is needed.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (ce_q) begin
            if (hc_q == HLast) begin
                bar_px_d  = '0;
                bar_idx_d = 3'd0;
            end else if (bar_px_q == BarLast) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    always_comb begin
        active      = (hc_q < HAct) && (vc_q < VAct);
        hsync_raw   = (hc_q >= HsStart) && (hc_q < HsEnd);
        vsync_raw   = (vc_q >= VsStart) && (vc_q < VsEnd);
        frame_start = (hc_q == 12'd0) && (vc_q == 12'd0);
    end

    // The frame's first pixel already uses the freshly sampled pattern selection.
    always_comb begin
        pat_eff = frame_start ? pattern_sel : pat_q;
        col_eff = frame_start ? pattern_color : col_q;
        pat_d   = (ce_q && frame_start) ? pattern_sel : pat_q;
        col_d   = (ce_q && frame_start) ? pattern_color : col_q;
    end

    always_comb begin
        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        case (pat_eff)
            PatSolid: pat_rgb = col_eff;
            PatBars:  pat_rgb = bar_rgb;
            PatGrid:  pat_rgb = ((hc_q[3:0] == 4'd0) || (vc_q[3:0] == 4'd0)) ?
                                24'hFFFFFF : 24'h000000;
            PatGrad:  pat_rgb = {hc_q[7:0], vc_q[7:0], fc_q[7:0]};
            default:  pat_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        x_d   = x_q;
        y_d   = y_q;
        rgb_d = rgb_q;
        if (ce_q) begin
            de_d  = active;
            hs_d  = hsync_raw;
            vs_d  = vsync_raw;
            x_d   = hc_q;
            y_d   = vc_q;
            rgb_d = active ? pat_rgb : 24'h000000;
        end
    end

    // Counts at the first vsync line, i.e. once per completed visible frame.
    always_comb begin
        fc_d = fc_q;
        if (ce_q && (hc_q == 12'd0) && (vc_q == VsStart)) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            ce_q      <= 1'b0;
            hc_q      <= 12'd0;
            vc_q      <= 12'd0;
            bar_px_q  <= '0;
            bar_idx_q <= 3'd0;
            pat_q     <= 2'd0;
            col_q     <= 24'h000000;
            fc_q      <= 16'd0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            rgb_q     <= 24'h000000;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
        end else begin
            div_q     <= div_d;
            ce_q      <= ce_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            col_q     <= col_d;
            fc_q      <= fc_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    assign pix_ce      = ce_q;
    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign rgb         = rgb_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (24x10 totals, 16x6 active, CLK_DIV=2).
module tb_video_timing_gen;

    localparam int CD  = 2;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic        clk;
    logic        reset;
    logic [1:0]  pattern_sel;
    logic [23:0] pattern_color;
    logic        pix_ce;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] frame_count;

    video_timing_gen #(
        .CLK_DIV  (CD),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pattern_sel   (pattern_sel),
        .pattern_color (pattern_color),
        .pix_ce        (pix_ce),
        .de            (de),
        .hs            (hs),
        .vs            (vs),
        .rgb           (rgb),
        .x             (x),
        .y             (y),
        .frame_count   (frame_count)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
    } pix_t;

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] col;
        int          px;
        int          py;
        logic [23:0] exp;
        bit          add_fc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    pix_t        sb[$];
    pix_t        hold = '0;
    pix_t        m_e;
    int          m_div = 0;
    bit          m_ce = 0;
    int          m_hc = 0;
    int          m_vc = 0;
    logic [15:0] m_fc = '0;
    logic [1:0]  m_pat = '0;
    logic [23:0] m_col = '0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(int hc, int vc);
        case (m_pat)
            2'd0:    return m_col;
            2'd1:    return bars[hc / (HA / 8)];
            2'd2:    return (((hc % 16) == 0) || ((vc % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
            default: return {8'(hc), 8'(vc), m_fc[7:0]};
        endcase
    endfunction

    // Reference raster: pushes the expected output tuple on every pixel-enable edge.
    always @(posedge clk) begin
        if (reset) begin
            m_div = 0;
            m_ce  = 0;
            m_hc  = 0;
            m_vc  = 0;
            m_fc  = '0;
            m_pat = '0;
            m_col = '0;
            hold  = '0;
            sb.delete();
        end else begin
            if (m_ce) begin
                if (m_hc == 0 && m_vc == 0) begin
                    m_pat = pattern_sel;
                    m_col = pattern_color;
                end
                m_e.de  = (m_hc < HA) && (m_vc < VA);
                m_e.hs  = (m_hc >= HA + HFP) && (m_hc < HA + HFP + HS);
                m_e.vs  = (m_vc >= VA + VFP) && (m_vc < VA + VFP + VS);
                m_e.x   = 12'(m_hc);
                m_e.y   = 12'(m_vc);
                m_e.rgb = m_e.de ? model_rgb(m_hc, m_vc) : 24'h000000;
                sb.push_back(m_e);
                if (m_hc == 0 && m_vc == VA + VFP) m_fc = m_fc + 16'd1;
                m_hc++;
                if (m_hc == HT) begin
                    m_hc = 0;
                    m_vc++;
                    if (m_vc == VT) m_vc = 0;
                end
            end
            m_div = (m_div == CD - 1) ? 0 : m_div + 1;
            m_ce  = (m_div == CD - 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb.size() > 0) hold = sb.pop_front();
            check("pixel", 64'({de, hs, vs, rgb, x, y}), 64'(hold));
            check("fc_ce", 64'({frame_count, pix_ce}), 64'({m_fc, m_ce}));
        end
    end

    task automatic next_pix();
        int n = 0;
        while (pix_ce !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic seek(input int px, input int py, output bit ok);
        ok = 0;
        for (int i = 0; i < HT * VT + 60; i++) begin
            if (int'(x) == px && int'(y) == py) begin
                ok = 1;
                break;
            end
            next_pix();
        end
    endtask

    task automatic frame_start(output bit ok);
        next_pix();
        seek(0, 0, ok);
    endtask

    // Entered with the output showing pixel (0,0) of a fresh frame after reset.
    task automatic run_frame_checks();
        int  de_cnt = 0, rises = 0, first_rise = -1, wmin = 9999, wmax = 0, run = 0;
        int  vs_cnt = 0, vs_first = -1;
        bit  prev_hs = 0;
        for (int p = 0; p < HT * VT; p++) begin
            if (p > 0) next_pix();
            if (de) de_cnt++;
            if (hs && !prev_hs) begin
                rises++;
                run = 1;
                if (first_rise < 0) first_rise = int'(x);
            end else if (hs) begin
                run++;
            end else if (prev_hs) begin
                if (run < wmin) wmin = run;
                if (run > wmax) wmax = run;
            end
            prev_hs = hs;
            if (vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = int'(y);
            end
        end
        check("de_count", 64'(de_cnt), 64'(HA * VA));
        check("hs_pulses", 64'(rises), 64'(VT));
        check("hs_first_x", 64'(first_rise), 64'(HA + HFP));
        check("hs_wmin", 64'(wmin), 64'(HS));
        check("hs_wmax", 64'(wmax), 64'(HS));
        check("vs_pixels", 64'(vs_cnt), 64'(VS * HT));
        check("vs_first_y", 64'(vs_first), 64'(VA + VFP));
        check("frame_end_xy", 64'({x, y}), 64'({12'(HT - 1), 12'(VT - 1)}));
        check("frame_count", 64'(frame_count), 64'(1));
    endtask

    task automatic release_and_frame();
        reset = 1'b0;
        @(negedge clk);
        check("first_ce", 64'(pix_ce), 64'(1));
        check("pre_ce_out", 64'({de, hs, vs, rgb, x, y}), 64'(0));
        @(negedge clk);
        check("second_ce", 64'(pix_ce), 64'(0));
        check("origin", 64'({de, x, y}), 64'({1'b1, 12'd0, 12'd0}));
        run_frame_checks();
    endtask

    initial begin
        #800000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        vec_t        tbl [16];
        bit          ok;
        logic [23:0] exp;

        tbl[0]  = '{2'd1, 24'h000000, 0, 0, 24'hFFFFFF, 1'b0};
        tbl[1]  = '{2'd1, 24'h000000, 3, 0, 24'hFFFF00, 1'b0};
        tbl[2]  = '{2'd1, 24'h000000, 5, 1, 24'h00FFFF, 1'b0};
        tbl[3]  = '{2'd1, 24'h000000, 6, 2, 24'h00FF00, 1'b0};
        tbl[4]  = '{2'd1, 24'h000000, 9, 3, 24'hFF00FF, 1'b0};
        tbl[5]  = '{2'd1, 24'h000000, 10, 0, 24'hFF0000, 1'b0};
        tbl[6]  = '{2'd1, 24'h000000, 13, 5, 24'h0000FF, 1'b0};
        tbl[7]  = '{2'd1, 24'h000000, 15, 0, 24'h000000, 1'b0};
        tbl[8]  = '{2'd1, 24'hFFFFFF, 16, 0, 24'h000000, 1'b0};
        tbl[9]  = '{2'd2, 24'h000000, 0, 3, 24'hFFFFFF, 1'b0};
        tbl[10] = '{2'd2, 24'h000000, 5, 0, 24'hFFFFFF, 1'b0};
        tbl[11] = '{2'd2, 24'h000000, 5, 3, 24'h000000, 1'b0};
        tbl[12] = '{2'd0, 24'h5A5A5A, 7, 5, 24'h5A5A5A, 1'b0};
        tbl[13] = '{2'd0, 24'h5A5A5A, 7, 6, 24'h000000, 1'b0};
        tbl[14] = '{2'd3, 24'h000000, 5, 3, 24'h050300, 1'b1};
        tbl[15] = '{2'd3, 24'h000000, 15, 5, 24'h0F0500, 1'b1};

        reset         = 1'b1;
        pattern_sel   = 2'd0;
        pattern_color = 24'h000000;
        @(negedge clk);
        chk_en = 1;
        repeat (4) @(negedge clk);
        check("reset_out", 64'({de, hs, vs, rgb, x, y, pix_ce}), 64'(0));
        release_and_frame();

        for (int i = 0; i < 16; i++) begin
            pattern_sel   = tbl[i].sel;
            pattern_color = tbl[i].col;
            frame_start(ok);
            seek(tbl[i].px, tbl[i].py, ok);
            check("tbl_seek", 64'(ok), 64'(1));
            exp = tbl[i].exp | (tbl[i].add_fc ? {16'h0000, m_fc[7:0]} : 24'h000000);
            check($sformatf("tbl_rgb[%0d]", i), 64'(rgb), 64'(exp));
        end

        // Colour change mid-frame must not disturb the frame in progress.
        pattern_sel   = 2'd0;
        pattern_color = 24'h123456;
        frame_start(ok);
        seek(0, 3, ok);
        pattern_color = 24'hABCDEF;
        seek(5, 4, ok);
        check("old_colour", 64'({ok, rgb}), 64'({1'b1, 24'h123456}));
        frame_start(ok);
        check("new_origin", 64'({ok, rgb}), 64'({1'b1, 24'hABCDEF}));
        seek(5, 1, ok);
        check("new_colour", 64'({ok, rgb}), 64'({1'b1, 24'hABCDEF}));

        pattern_sel = 2'd3;
        for (int k = 0; k < 3; k++) begin
            frame_start(ok);
            seek(1, 1, ok);
            check("grad_blue", 64'({ok, rgb}), 64'({1'b1, 8'h01, 8'h01, m_fc[7:0]}));
        end

        // One-clock reset deep in the back porch, then a clean restart.
        seek(22, 9, ok);
        check("mid_seek", 64'(ok), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset", 64'({de, hs, vs, rgb, x, y, frame_count, pix_ce}), 64'(0));
        release_and_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
